// File: rtl/rdout_stream_pkg.sv
// Shared types and constants for the DPRAM readout streamer.
// The optional RDOUT_STREAM_CRC16_EN build uses the CRC constants below.
package rdout_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int          SUBWORDS = 4;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One extra bit so the clamped maximum length fits without overflow.
    function automatic int cnt_width(input int len_width);
        return len_width + 1;
    endfunction

endpackage

// File: rtl/dpram_rdout_streamer_if.sv
// 16-bit valid/ready readout stream toward the ICM/host path.
interface dpram_rdout_streamer_if;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/crc16_ccitt_w16.sv
// Combinational CRC-16/CCITT step over one 16-bit word, MSB first.
module crc16_ccitt_w16
    import rdout_stream_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [15:0] data,
    output logic [15:0] crc_next
);

    logic [15:0] c;

    // Word width equals CRC width, so the whole word folds in before shifting.
    always_comb begin
        c = crc ^ data;
        for (int i = 0; i < 16; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        end
        crc_next = c;
    end

endmodule

// File: rtl/dpram_rdout_streamer.sv
// Drains the wvb_reader readout DPRAM (port B) as a 16-bit valid/ready stream.
// Define RDOUT_STREAM_CRC16_EN to append a CRC-16/CCITT word after the payload.
//
// state  | meaning
// IDLE   | waiting for dpram_run; length latched on the run cycle
// STREAM | reading DPRAM and emitting words; dpram_busy high
// DONE   | one-cycle dpram_done pulse, then back to IDLE
module dpram_rdout_streamer
    import rdout_stream_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 9,
    parameter int P_LEN_WIDTH  = 16,
    parameter int P_RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dpram_run,
    input  logic [P_LEN_WIDTH-1:0]  dpram_len,
    output logic                    dpram_busy,
    output logic                    dpram_done,
    output logic [P_ADDR_WIDTH-1:0] rd_addr,
    input  logic [63:0]             rd_data,
    dpram_rdout_streamer_if.master  m
);

    localparam int             CW        = cnt_width(P_LEN_WIDTH);
    localparam int             LEN_MAX_I = SUBWORDS * (2 ** P_ADDR_WIDTH);
    localparam logic [CW-1:0]  LEN_MAX   = CW'(LEN_MAX_I);

    state_t                  state, state_nxt;
    logic [CW-1:0]           len_q, sent_cnt, rd_left, len_in;
    logic [63:0]             hold_q, pf_q;
    logic                    hold_vld, pf_vld;
    logic [1:0]              sub_idx;
    logic [P_RD_LATENCY-1:0] pipe;
    logic [2:0]              inflight, occ;
    logic                    xfer, is_last_pl, hold_pop, issue, arrive, stream_end;
    logic [15:0]             pl_word;

    assign len_in = ({1'b0, dpram_len} > LEN_MAX) ? LEN_MAX : {1'b0, dpram_len};

    always_comb begin
        inflight = '0;
        for (int i = 0; i < P_RD_LATENCY; i++) begin
            inflight = inflight + 3'(pipe[i]);
        end
    end

    // Only two 64-bit slots (hold + prefetch) exist; in-flight reads already own one.
    assign occ        = 3'(hold_vld) + 3'(pf_vld) + inflight;
    assign issue      = (state == ST_STREAM) && (rd_left != '0) && (occ < 3'd2);
    assign arrive     = (state == ST_STREAM) && pipe[P_RD_LATENCY-1];
    assign pl_word    = hold_q[{sub_idx, 4'b0000} +: 16];
    assign xfer       = m.m_valid && m.m_ready;
    assign is_last_pl = hold_vld && (sent_cnt == len_q - CW'(1));
    assign hold_pop   = xfer && hold_vld && ((sub_idx == 2'd3) || is_last_pl);

`ifdef RDOUT_STREAM_CRC16_EN
    logic [15:0] crc_q, crc_nxt;
    logic        crc_phase;

    crc16_ccitt_w16 u_crc (
        .crc      (crc_q),
        .data     (pl_word),
        .crc_next (crc_nxt)
    );

    assign crc_phase  = (state == ST_STREAM) && !hold_vld && (sent_cnt == len_q);
    assign stream_end = xfer && crc_phase;

    always_comb begin
        m.m_valid = hold_vld || crc_phase;
        m.m_last  = crc_phase;
        m.m_data  = '0;
        if (crc_phase)     m.m_data = crc_q;
        else if (hold_vld) m.m_data = pl_word;
    end

    always_ff @(posedge clk) begin
        if (!rst)                    crc_q <= '0;
        else if (state == ST_IDLE)   crc_q <= CRC_INIT;
        else if (xfer && hold_vld)   crc_q <= crc_nxt;
    end
`else
    assign stream_end = (len_q == '0) || (xfer && is_last_pl);

    always_comb begin
        m.m_valid = hold_vld;
        m.m_last  = is_last_pl;
        m.m_data  = hold_vld ? pl_word : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        dpram_busy = 1'b0;
        dpram_done = 1'b0;
        case (state)
            ST_IDLE:   if (dpram_run) state_nxt = ST_STREAM;
            ST_STREAM: begin
                dpram_busy = 1'b1;
                if (stream_end) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                dpram_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q    <= '0;
            sent_cnt <= '0;
            rd_left  <= '0;
            rd_addr  <= '0;
            hold_q   <= '0;
            pf_q     <= '0;
            hold_vld <= 1'b0;
            pf_vld   <= 1'b0;
            sub_idx  <= '0;
            pipe     <= '0;
        end else begin
            pipe <= (pipe << 1) | P_RD_LATENCY'(issue);
            if (state == ST_IDLE) begin
                if (dpram_run) begin
                    len_q    <= len_in;
                    rd_left  <= (len_in + CW'(3)) >> 2;
                    sent_cnt <= '0;
                    rd_addr  <= '0;
                    hold_vld <= 1'b0;
                    pf_vld   <= 1'b0;
                    sub_idx  <= '0;
                end
            end else if (state == ST_STREAM) begin
                if (issue) begin
                    rd_left <= rd_left - CW'(1);
                    if (rd_left > CW'(1)) rd_addr <= rd_addr + P_ADDR_WIDTH'(1);
                end
                if (xfer && hold_vld) begin
                    sent_cnt <= sent_cnt + CW'(1);
                    sub_idx  <= hold_pop ? 2'd0 : sub_idx + 2'd1;
                end
                if (!hold_vld || hold_pop) begin
                    if (pf_vld) begin
                        hold_q   <= pf_q;
                        hold_vld <= 1'b1;
                        pf_vld   <= arrive;
                        if (arrive) pf_q <= rd_data;
                    end else begin
                        hold_vld <= arrive;
                        if (arrive) hold_q <= rd_data;
                    end
                end else if (arrive) begin
                    pf_q   <= rd_data;
                    pf_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dpram_rdout_streamer.sv
// Scoreboard bench for dpram_rdout_streamer with a behavioural DPRAM and reference model.
module tb_dpram_rdout_streamer;

    localparam int AW   = 9;
    localparam int LW   = 16;
    localparam int RL   = 1;
    localparam int NMAX = 4 * (2 ** AW);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           dpram_run = 1'b0;
    logic [LW-1:0]  dpram_len = '0;
    logic           dpram_busy, dpram_done;
    logic [AW-1:0]  rd_addr;
    logic [63:0]    rd_data, d1, d2;

    dpram_rdout_streamer_if sif ();

    dpram_rdout_streamer #(
        .P_ADDR_WIDTH (AW),
        .P_LEN_WIDTH  (LW),
        .P_RD_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dpram_run  (dpram_run),
        .dpram_len  (dpram_len),
        .dpram_busy (dpram_busy),
        .dpram_done (dpram_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m          (sif)
    );

    logic [63:0] mem [2**AW];
    logic [16:0] exp_q [$];
    logic [16:0] e;
    int cyc = 0, n_vec = 0, n_err = 0;
    int first_valid_cyc, last_xfer_cyc, done_cyc, done_cnt, busy_cnt, max_addr, run_cyc;
    int ready_mode = 0, tog = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        d1 <= mem[rd_addr];
        d2 <= d1;
    end
    assign rd_data = (RL == 1) ? d1 : d2;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) sif.m_ready = 1'b1;
        else if (ready_mode == 1) begin
            sif.m_ready = (tog == 0);
            tog = (tog + 1) % 3;
        end else sif.m_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [15:0] w);
        logic [15:0] c = crc;
        for (int i = 15; i >= 0; i--) begin
            logic fb = c[15] ^ w[i];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst) prev_stall = 1'b0;
        else begin
            if (prev_stall)
                chk("stall_hold", {sif.m_valid, sif.m_last, sif.m_data}, {1'b1, prev_last, prev_data});
            if (sif.m_valid) begin
                chk("valid_in_busy", dpram_busy, 1);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (sif.m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h, expected no word", sif.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_word", {sif.m_last, sif.m_data}, e);
                    end
                    last_xfer_cyc = cyc;
                end
                prev_stall = !sif.m_ready;
                prev_data  = sif.m_data;
                prev_last  = sif.m_last;
            end else prev_stall = 1'b0;
            if (dpram_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", dpram_busy, 0);
            end
            if (dpram_busy) begin
                busy_cnt++;
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            end
        end
    end

    // Reference: subword k of the event is 16-bit lane k%4 of DPRAM word k/4.
    task automatic expect_event(input int len, output int n, output int nw);
        logic [63:0] tmp;
        logic [15:0] w;
        logic [15:0] crc = 16'hFFFF;
        n = (len > NMAX) ? NMAX : len;
        for (int k = 0; k < n; k++) begin
            tmp = mem[k / 4];
            w   = tmp[16 * (k % 4) +: 16];
            crc = crc_upd(crc, w);
`ifdef RDOUT_STREAM_CRC16_EN
            exp_q.push_back({1'b0, w});
`else
            exp_q.push_back({k == n - 1, w});
`endif
        end
`ifdef RDOUT_STREAM_CRC16_EN
        exp_q.push_back({1'b1, crc});
        nw = n + 1;
`else
        nw = n;
`endif
    endtask

    task automatic start_run(input int len);
        @(posedge clk);
        #1;
        dpram_len = LW'(len);
        dpram_run = 1'b1;
        run_cyc   = cyc + 1;
        @(posedge clk);
        #1;
        dpram_run = 1'b0;
        dpram_len = LW'($urandom);
    endtask

    task automatic run_event(input int len, input int rmode, input bit inject);
        int n, nw, budget;
        expect_event(len, n, nw);
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        busy_cnt        = 0;
        max_addr        = 0;
        ready_mode      = rmode;
        tog             = 0;
        start_run(len);
        if (inject) begin
            repeat (3) @(posedge clk);
            #1;
            dpram_run = 1'b1;
            dpram_len = LW'(3);
            @(posedge clk);
            #1;
            dpram_run = 1'b0;
        end
        budget = 0;
        while (done_cnt == 0 && budget < 4 * nw + 50) begin
            @(posedge clk);
            budget++;
        end
        if (done_cnt == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done after %0d cycles, expected one", budget);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("words_left", exp_q.size(), 0);
        exp_q.delete();
        chk("busy_span", busy_cnt, done_cyc - run_cyc);
        if (n > 0) begin
            chk("first_latency", first_valid_cyc - run_cyc, RL + 1);
            chk("done_after_last", done_cyc, last_xfer_cyc + 1);
            chk("rd_addr_max", max_addr, (n + 3) / 4 - 1);
        end else begin
            chk("len0_done_time", done_cyc - run_cyc, 1);
        end
        if (rmode == 0 && nw > 0) chk("no_bubble", last_xfer_cyc - first_valid_cyc, nw - 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},    dpram_busy,  0);
        chk({tag, "_done"},    dpram_done,  0);
        chk({tag, "_rd_addr"}, rd_addr,     0);
        chk({tag, "_m_data"},  sif.m_data,  0);
        chk({tag, "_m_valid"}, sif.m_valid, 0);
        chk({tag, "_m_last"},  sif.m_last,  0);
    endtask

    task automatic reset_abort();
        int n, nw;
        expect_event(20, n, nw);
        ready_mode = 0;
        done_cnt   = 0;
        start_run(20);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_idle("abort");
        rst      = 1'b1;
        done_cnt = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2 ** AW; i++) mem[i] = {$urandom, $urandom};
    endtask

    initial begin
        sif.m_ready = 1'b1;
        fill_random();
        mem[0] = 64'h0004_0003_0002_0001;
        mem[1] = 64'h0008_0007_0006_0005;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;

        run_event(8, 0, 1'b0);
        run_event(6, 0, 1'b0);
        run_event(8, 1, 1'b0);
        run_event(0, 0, 1'b0);
        run_event(8, 0, 1'b1);
        reset_abort();
        run_event(4, 0, 1'b0);

        fill_random();
        run_event(NMAX + 10, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            fill_random();
            run_event(int'($urandom_range(0, 70)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/dpram_rdout_streamer.md
Name: dpram_rdout_streamer

Overview:
- Consumer side of the wvb_reader DPRAM handoff.
- On a dpram_run pulse, it latches dpram_len (in 16-bit words) and reads the 64-bit readout DPRAM port B from address 0.
- It serialises the contents as 16-bit words on a valid/ready stream toward the ICM/host readout path.
- It drives dpram_busy for the whole transfer and pulses dpram_done when the last word is accepted, which releases wvb_reader to fill the next event.

Parameters:
- P_ADDR_WIDTH, 9, DPRAM port-B address width (64-bit words).
- P_LEN_WIDTH, 16, width of dpram_len (count of 16-bit words).
- P_RD_LATENCY, 1, DPRAM port-B read latency in cycles (1 or 2 supported).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- dpram_run  in  1  single-cycle start pulse from wvb_reader
- dpram_len  in  P_LEN_WIDTH  event length in 16-bit words; sampled on dpram_run
- dpram_busy  out  1  transfer in progress
- dpram_done  out  1  single-cycle completion pulse
- rd_addr  out  P_ADDR_WIDTH  DPRAM port-B address
- rd_data  in  64  DPRAM port-B data, valid P_RD_LATENCY cycles after rd_addr
- m_data  out  16  stream word
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_last  out  1  marks the final word of an event (CRC word when enabled)

Behaviour:
- Clock and reset: reset rst, synchronous, active-low; clock clk.
- Reset values (rst==0 at a clk edge): dpram_busy=0, dpram_done=0, rd_addr=0, m_data=0, m_valid=0, m_last=0, FSM=IDLE, all counters 0.
- Reset mid-transfer aborts immediately. No done pulse is issued, and an in-flight read is discarded.
- FSM states:
  - IDLE: wait for dpram_run. On dpram_run, latch len = min(dpram_len, 4*2^P_ADDR_WIDTH), set busy=1 on the next cycle, and set rd_addr=0.
    - If len==0, go to DONE directly: busy high for exactly 1 cycle, then the done pulse. No stream output.
  - STREAM: emit words. Handshake: a word transfers on a cycle with m_valid && m_ready.
    - m_data, m_valid and m_last stay stable while m_valid && !m_ready.
    - m_valid never drops without a transfer.
  - DONE: one cycle. dpram_done=1 and dpram_busy=0 in that same cycle, then return to IDLE.
- Word order: within a 64-bit DPRAM word, bits[15:0] go first, then [31:16], [47:32], [63:48]. DPRAM addresses are read ascending.
- Buffering: a 64-bit holding register plus one 64-bit prefetch register.
  - A read is issued whenever the prefetch register is empty or will be empty when the data returns, and unread 64-bit words remain.
  - Required sustained throughput with m_ready held high: 1 word/cycle, with no bubbles after the first word.
- First-word latency: m_valid rises P_RD_LATENCY+1 cycles after the dpram_run edge.
- Partial final word: if len mod 4 != 0, only the low (len mod 4) subwords of the last DPRAM word are emitted. Upper subwords are never presented.
- Counters: rd_addr stops at ceil(len/4)-1 and never wraps. The word counter is P_LEN_WIDTH+1 bits wide so that the clamped maximum does not overflow.
- m_last is asserted with the final word only.
- The done pulse occurs in the cycle after the final word is accepted.
- dpram_run while busy is ignored and len is not re-latched. dpram_run in the same cycle as DONE is also ignored; a new run is accepted only from IDLE.
- dpram_len changes after the run cycle have no effect on the transfer.

Optional Feature:
- Macro RDOUT_STREAM_CRC16_EN.
- When defined: a CRC-16/CCITT (polynomial 0x1021, init 0xFFFF, MSB-first, over each 16-bit word) is computed over the payload words.
  - The CRC is emitted as one extra word after the payload. m_last moves to the CRC word.
  - For len==0, a single word 0xFFFF is emitted with m_last=1.
- When undefined: no CRC logic, and m_last marks the final payload word.

Decomposition:
- Shared package/include `rdout_stream_pkg`:
  - FSM state encodings (IDLE, STREAM, DONE)
  - subword-per-DPRAM-word constant (4)
  - CRC polynomial/init constants
  - word-count helper width localparam
- One sub-module `crc16_ccitt_w16`: combinational next-CRC from (crc, data16), instantiated only under RDOUT_STREAM_CRC16_EN.

Test Plan:
- len=8, DPRAM words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, m_ready=1 -> stream 1..8 on consecutive cycles, m_last on 8, done 1 cycle later, busy high from run+1 through the last transfer.
- len=6 -> stream 1..6 only, last on 6; words 7 and 8 never valid; rd_addr max 1.
- len=8, m_ready toggling 1,0,0,1,... -> identical sequence, m_data stable across stalls, single done pulse.
- len=0 -> no m_valid; busy high 1 cycle, then a done pulse (CRC build: one word 0xFFFF with last).
- Second dpram_run mid-transfer with len=3 -> ignored; first event completes intact. rst=0 mid-transfer -> all outputs 0, no done; a subsequent run with len=4 is clean.
- len=4*512+10 (clamped to 2048) -> 2048 words emitted, rd_addr reaches 511 without wrap, last on word 2048.
